// File: rtl/multiply_accumulate.sv
// Streaming signed fixed-point multiply-accumulate, one result per packet.
// Optional: define MULTIPLY_ACCUMULATE_SATURATE_EN to clamp res_data.
module multiply_accumulate #(
  parameter int ARGW = 16,
  parameter int FRAC = 8,
  parameter int RESW = 24,
  parameter int ACCW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arg_valid,
  output logic              arg_ready,
  input  logic [2*ARGW-1:0] arg_data,
  input  logic              arg_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RESW-1:0]   res_data
);

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    DONE
  } state_t;

  state_t state, next_state;

  logic signed [ARGW-1:0]   a, b;
  logic signed [2*ARGW-1:0] prod, prod_sh;
  logic signed [ACCW-1:0]   p_ext, p_reg;
  logic signed [ACCW-1:0]   acc, acc_sum;
  logic                     p_valid;
  logic [RESW-1:0]          res_conv;
  logic                     accept;
  logic                     ready_next;
  logic                     drain;
  logic                     res_fire;

  assign a = arg_data[2*ARGW-1:ARGW];
  assign b = arg_data[ARGW-1:0];

  assign prod    = a * b;
  assign prod_sh = prod >>> FRAC;
  assign p_ext   = ACCW'(prod_sh);

  assign accept  = arg_valid && arg_ready;
  assign acc_sum = acc + (p_valid ? p_reg : '0);

`ifdef MULTIPLY_ACCUMULATE_SATURATE_EN
  localparam logic signed [ACCW-1:0] RMAX =
    ACCW'((64'sd1 <<< (RESW-1)) - 64'sd1);
  localparam logic signed [ACCW-1:0] RMIN = ~RMAX;

  // Clamp the final sum into the signed result range.
  always_comb begin
    res_conv = acc_sum[RESW-1:0];
    if (acc_sum > RMAX)
      res_conv = RMAX[RESW-1:0];
    else if (acc_sum < RMIN)
      res_conv = RMIN[RESW-1:0];
  end
`else
  assign res_conv = acc_sum[RESW-1:0];
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ACC;
    else
      state <= next_state;
  end

  // Next-state logic: accumulate, fold last product, hold result.
  always_comb begin
    next_state = state;
    unique case (state)
      ACC:
        if (accept && arg_last)
          next_state = DRAIN;
      DRAIN:
        next_state = DONE;
      DONE:
        if (res_ready)
          next_state = ACC;
      default:
        next_state = ACC;
    endcase
  end

  // Decoded controls for the datapath registers.
  always_comb begin
    ready_next = (next_state == ACC);
    drain      = (state == DRAIN);
    res_fire   = (state == DONE) && res_ready;
  end

  // Product stage, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arg_ready <= 1'b0;
      p_valid   <= 1'b0;
      p_reg     <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      arg_ready <= ready_next;
      p_valid   <= accept;
      if (accept)
        p_reg <= p_ext;
      if (res_fire)
        acc <= '0;
      else
        acc <= acc_sum;
      if (drain) begin
        res_data  <= res_conv;
        res_valid <= 1'b1;
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiply_accumulate.sv
// Self-checking bench for multiply_accumulate.
// Packet-level arithmetic model plus directed literal checks.
module tb_multiply_accumulate;

  localparam int ARGW = 16;
  localparam int FRAC = 8;
  localparam int RESW = 24;
  localparam int ACCW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arg_valid = 1'b0;
  logic              arg_ready;
  logic [2*ARGW-1:0] arg_data = '0;
  logic              arg_last = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [RESW-1:0]   res_data;

  int passed = 0;
  int total  = 0;
  int hs     = 0;

  multiply_accumulate #(
    .ARGW(ARGW), .FRAC(FRAC), .RESW(RESW), .ACCW(ACCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arg_valid(arg_valid),
    .arg_ready(arg_ready),
    .arg_data(arg_data),
    .arg_last(arg_last),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Packet result from plain integer arithmetic.
  function automatic logic [RESW-1:0] mdl(input int qa[$], input int qb[$]);
    longint s = 0;
    longint mx = (64'sd1 <<< (RESW-1)) - 1;
    longint mn = -mx - 1;
    logic [63:0] r;
    for (int i = 0; i < qa.size(); i++)
      s += (longint'(qa[i]) * longint'(qb[i])) >>> FRAC;
    s = (s <<< (64-ACCW)) >>> (64-ACCW);
`ifdef MULTIPLY_ACCUMULATE_SATURATE_EN
    if (s > mx) s = mx;
    if (s < mn) s = mn;
`endif
    r = s;
    return r[RESW-1:0];
  endfunction

  int pa[$];
  int pb[$];
  logic [RESW-1:0] expq[$];

  // Per-cycle compare against the model, then model update.
  always @(negedge clk) begin
    static int cyc = 0;
    static int last_acc = 0;
    static bit prev_rv = 0;
    static bit prev_hs = 0;
    cyc++;
    if (rst) begin
      pa.delete();
      pb.delete();
      expq.delete();
      prev_rv = 0;
      prev_hs = 0;
      chk("rst_arg_ready", arg_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
    end else begin
      if (res_valid) begin
        chk("res_pending", expq.size() != 0, 1);
        if (expq.size() != 0)
          chk("res_data", res_data, expq[0]);
        chk("ready_low_while_res", arg_ready, 0);
        if (!prev_rv)
          chk("latency", cyc - last_acc, 2);
      end
      if (prev_rv && !prev_hs)
        chk("res_valid_held", res_valid, 1);
      if (arg_valid && arg_ready) begin
        pa.push_back(int'($signed(arg_data[2*ARGW-1:ARGW])));
        pb.push_back(int'($signed(arg_data[ARGW-1:0])));
        if (arg_last) begin
          expq.push_back(mdl(pa, pb));
          last_acc = cyc;
          pa.delete();
          pb.delete();
        end
      end
      prev_hs = res_valid && res_ready;
      if (prev_hs) begin
        if (expq.size() != 0)
          void'(expq.pop_front());
        hs++;
      end
      prev_rv = res_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic last, input bit b2b);
    int n = 0;
    arg_valid = 1'b1;
    arg_data  = {a, b};
    arg_last  = last;
    @(negedge clk);
    if (b2b)
      chk("b2b_ready", arg_ready, 1);
    while (!arg_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!arg_ready)
      chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    arg_valid = 1'b0;
    arg_data  = $urandom;
    arg_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic get_result(input logic [RESW-1:0] lit,
                            input string nm, input int hold);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!res_valid)
      chk({nm, "_timeout"}, 0, 1);
    chk(nm, res_data, lit);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_bp_valid"}, res_valid, 1);
      chk({nm, "_bp_data"}, res_data, lit);
      chk({nm, "_bp_ready"}, arg_ready, 0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_pre_hs"}, res_valid, 1);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_post_valid"}, res_valid, 0);
    chk({nm, "_post_ready"}, arg_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int qa[$];
    int qb[$];
    logic [RESW-1:0] ovf;

    qa = '{128};
    qb = '{128};
    chk("model_pin_half", mdl(qa, qb), 24'h000040);
    qa = '{-256};
    qb = '{128};
    chk("model_pin_neg", mdl(qa, qb), 24'hFFFF80);
    qa = '{-1};
    qb = '{1};
    chk("model_pin_floor", mdl(qa, qb), 24'hFFFFFF);
`ifdef MULTIPLY_ACCUMULATE_SATURATE_EN
    ovf = 24'h7FFFFF;
`else
    ovf = 24'hBFFD00;
`endif
    qa = '{32767, 32767, 32767};
    qb = '{32767, 32767, 32767};
    chk("model_pin_ovf", mdl(qa, qb), ovf);

    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", arg_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", arg_ready, 1);

    send(16'h0080, 16'h0080, 1'b1, 1'b1);
    get_result(24'h000040, "single", 0);

    send(16'h0100, 16'h0100, 1'b0, 1'b1);
    send(16'h0080, 16'h0080, 1'b1, 1'b1);
    get_result(24'h000140, "two_beat", 0);

    send(16'hFF00, 16'h0080, 1'b1, 1'b1);
    get_result(24'hFFFF80, "signed", 0);

    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    send(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
    send(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    get_result(ovf, "overflow", 0);

    send(16'h0200, 16'h0180, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    send(16'hFFFF, 16'h0001, 1'b1, 1'b1);
    get_result(24'h0002FF, "backpressure", 5);

    send(16'h0100, 16'h0100, 1'b0, 1'b1);
    send(16'h0100, 16'h0100, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", arg_ready, 0);
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_data", res_data, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0100, 16'h0100, 1'b1, 1'b0);
    get_result(24'h000100, "after_reset", 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    chk("handshakes", hs, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multiply_accumulate.md
Name: multiply_accumulate

Overview:
- Streaming signed fixed-point multiply-accumulate for neuron dot products; successor to the single-shot multiply unit.
- Takes packed argument pairs over a valid/ready stream and accumulates their products over a packet delimited by arg_last.
- Emits one result per packet over a valid/ready stream.
- Widths, fraction point and accumulator width are parametrised.

Parameters:
- ARGW, 16, width of each signed argument (Q(ARGW-FRAC).FRAC)
- FRAC, 8, fractional bits of arguments and result
- RESW, 24, width of signed result
- ACCW, 32, internal accumulator width; must satisfy ACCW >= RESW and ACCW >= 2*ARGW-FRAC

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- arg_valid  input  1  argument beat valid
- arg_ready  output  1  argument beat accepted when valid and ready both high
- arg_data  input  2*ARGW  {a, b}; a = arg_data[2*ARGW-1:ARGW], b = arg_data[ARGW-1:0]
- arg_last  input  1  final beat of packet, qualified by arg_valid
- res_valid  output  1  result valid
- res_ready  input  1  result accepted when valid and ready both high
- res_data  output  RESW  accumulated signed result

Behaviour:
- Reset (async assert, applied immediately):
  - arg_ready=0, res_valid=0, res_data=0, accumulator=0, product stage empty, state=ACC.
  - arg_ready rises on the first clk edge after rst deasserts.
- Arithmetic:
  - p = signed(a)*signed(b), full 2*ARGW bits.
  - p is arithmetically shifted right by FRAC (truncation toward -inf) and sign-extended to ACCW.
  - acc += p, two's complement, wraps at ACCW.
- Pipeline:
  - Stage P registers the shifted product on the accept edge.
  - Accumulator adds stage P on the next edge.
  - Full throughput of one beat per cycle while in ACC.
- FSM:
  - ACC: arg_ready=1. A beat accepted with arg_last=1 moves to DRAIN. A non-last accept stays in ACC.
  - DRAIN: arg_ready=0. Stage P is folded into acc. res_data loads the final value. res_valid=1. Next state is DONE. Duration is one cycle.
  - DONE: arg_ready=0; res_valid=1; res_data held stable. On res handshake: acc cleared to 0, res_valid=0, arg_ready=1, state=ACC, all on that edge.
- Latency: res_valid rises on the 2nd rising edge counting the edge that accepts the last beat.
- Packet boundaries:
  - A single-beat packet (arg_last on the first beat) is legal.
  - Empty packets do not exist.
- Handshake rules:
  - arg_data and arg_last are ignored when arg_valid=0.
  - res_valid, once high, never drops before the handshake.
  - res_ready while res_valid=0 has no effect.
- Reset mid-packet or while DONE discards the partial sum and any pending result; no result is emitted.
- Output conversion: res_data = acc[RESW-1:0] (wrap), unless the optional feature below is enabled.

Optional Feature:
- Macro: MULTIPLY_ACCUMULATE_SATURATE_EN.
- Defined:
  - When loading res_data, acc values above 2^(RESW-1)-1 clamp to 2^(RESW-1)-1.
  - Values below -2^(RESW-1) clamp to -2^(RESW-1).
  - The accumulator itself still wraps at ACCW.
- Undefined: plain truncation to the low RESW bits; no comparators are synthesised.

Test Plan:
- Single beat {0x0080,0x0080}, last=1 -> res_data=24'h000040; res_valid on 2nd edge after accept.
- Two beats {0x0100,0x0100}, {0x0080,0x0080} with last on beat 2 -> res_data=24'h000140. arg_ready is high both cycles (back-to-back accepts).
- Signed case {0xFF00,0x0080}, last=1 -> res_data=24'hFFFF80 (-0.5).
- Overflow: three beats of {0x7FFF,0x7FFF}, last on beat 3 -> res_data=24'hBFFD00 without the macro; 24'h7FFFFF with MULTIPLY_ACCUMULATE_SATURATE_EN.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_valid stays 1, res_data stable, arg_ready stays 0. Raising res_ready gives exactly one handshake, then arg_ready=1 on the next cycle.
- Reset mid-packet: two non-last beats {0x0100,0x0100}, then pulse rst asynchronously between edges -> outputs zero immediately. Then send {0x0100,0x0100} with last=1 -> res_data=24'h000100, with no stale sum.
